// File: rtl/card_dealer.sv
// card_dealer
//   Card source and hand accumulator sitting in front of the blackjack game
//   FSM. On a deal request it draws a rank (free-running LFSR or a forced
//   test rank), adds the card value to the selected hand with soft-ace
//   demotion, and hands back a card_ready handshake plus hand status.
//
// Optional feature macro: HIT_SOFT17_EN
//   defined   -> dealer_auto_hit also asserts on a soft 17
//   undefined -> dealer_auto_hit = (dealer_sum < DEALER_STAND) && !dealer_bust
//
// Ports
//   clk              system clock
//   rst              asynchronous reset, active low
//   deal_player      player card request (level, held until card_ready)
//   deal_dealer      dealer card request (level, held until card_ready)
//   clear_sums       synchronous clear of both hands, aborts an in-flight card
//   test_en          1 = take the rank from test_rank instead of the LFSR
//   test_rank[3:0]   forced rank; 0 or >13 is treated as 13
//   card_ready       card committed (READY/HOLD states)
//   last_rank[3:0]   rank of the most recently drawn card
//   player_sum[5:0]  player hand total (saturates at 63)
//   dealer_sum[5:0]  dealer hand total (saturates at 63)
//   player_bust      player_sum > BUST_LIMIT
//   dealer_bust      dealer_sum > BUST_LIMIT
//   dealer_auto_hit  dealer must take another card
//   player_cards     player card count, saturating at 15
//   dealer_cards     dealer card count, saturating at 15
module card_dealer #(
  parameter logic [15:0] LFSR_SEED    = 16'hACE1,
  parameter int          DEALER_STAND = 17,
  parameter int          BUST_LIMIT   = 21
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       deal_player,
  input  logic       deal_dealer,
  input  logic       clear_sums,
  input  logic       test_en,
  input  logic [3:0] test_rank,
  output logic       card_ready,
  output logic [3:0] last_rank,
  output logic [5:0] player_sum,
  output logic [5:0] dealer_sum,
  output logic       player_bust,
  output logic       dealer_bust,
  output logic       dealer_auto_hit,
  output logic [3:0] player_cards,
  output logic [3:0] dealer_cards
);

  localparam logic [6:0] BUST7  = 7'(BUST_LIMIT);
  localparam logic [5:0] BUST6  = 6'(BUST_LIMIT);
  localparam logic [5:0] STAND6 = 6'(DEALER_STAND);

  typedef enum logic [2:0] {
    S_IDLE,
    S_DRAW,
    S_ADD,
    S_READY,
    S_HOLD
  } state_t;

  state_t      state, next_state;
  logic [15:0] lfsr;
  logic [15:0] lfsr_next;
  logic        tgt_player;
  logic [1:0]  player_soft;
  logic [1:0]  dealer_soft;

  logic [3:0]  draw_rank;
  logic        draw_ok;
  logic        req_held;
  logic [5:0]  cur_sum;
  logic [1:0]  cur_soft;
  logic [6:0]  sum7;
  logic [1:0]  soft_next;
  logic [5:0]  add_sum;

  function automatic logic [3:0] norm_rank(input logic [3:0] r);
    return ((r == 4'd0) || (r > 4'd13)) ? 4'd13 : r;
  endfunction

  function automatic logic [6:0] card_value(input logic [3:0] r);
    if (r == 4'd1)
      return 7'd11;
    else if (r >= 4'd10)
      return 7'd10;
    else
      return {3'b000, r};
  endfunction

  function automatic logic [5:0] sat_sum(input logic [6:0] s);
    return (s > 7'd63) ? 6'd63 : s[5:0];
  endfunction

  function automatic logic [3:0] sat_cnt(input logic [3:0] c);
    return (c == 4'hF) ? c : c + 4'd1;
  endfunction

  // Fibonacci LFSR, taps 16,14,13,11
  assign lfsr_next = {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};

  // LFSR nibbles 0, 14 and 15 are not ranks; DRAW simply retries next cycle
  assign draw_rank = test_en ? norm_rank(test_rank) : lfsr[3:0];
  assign draw_ok   = test_en || ((lfsr[3:0] != 4'd0) && (lfsr[3:0] <= 4'd13));
  assign req_held  = tgt_player ? deal_player : deal_dealer;

  // Hand update for the card latched in last_rank; at most one ace demoted
  // per card keeps the soft count at 0 or 1 after every update.
  always_comb begin
    cur_sum   = tgt_player ? player_sum  : dealer_sum;
    cur_soft  = tgt_player ? player_soft : dealer_soft;
    sum7      = {1'b0, cur_sum} + card_value(last_rank);
    soft_next = cur_soft + {1'b0, (last_rank == 4'd1)};
    if ((sum7 > BUST7) && (soft_next != 2'd0)) begin
      sum7      = sum7 - 7'd10;
      soft_next = soft_next - 2'd1;
    end
    add_sum = sat_sum(sum7);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      state <= S_IDLE;
    else
      state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      S_IDLE:  if (deal_player || deal_dealer) next_state = S_DRAW;
      S_DRAW:  if (draw_ok) next_state = S_ADD;
      S_ADD:   next_state = S_READY;
      S_READY: if (!req_held) next_state = S_HOLD;
      S_HOLD:  next_state = S_IDLE;
      default: next_state = S_IDLE;
    endcase
    if (clear_sums)
      next_state = S_IDLE;
  end

  // ---- request latch / draw / accumulate ----
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      lfsr         <= LFSR_SEED;
      card_ready   <= 1'b0;
      tgt_player   <= 1'b0;
      last_rank    <= 4'd0;
      player_sum   <= 6'd0;
      dealer_sum   <= 6'd0;
      player_soft  <= 2'd0;
      dealer_soft  <= 2'd0;
      player_cards <= 4'd0;
      dealer_cards <= 4'd0;
    end else begin
      lfsr       <= lfsr_next;
      card_ready <= (next_state == S_READY) || (next_state == S_HOLD);
      if (clear_sums) begin
        player_sum   <= 6'd0;
        dealer_sum   <= 6'd0;
        player_soft  <= 2'd0;
        dealer_soft  <= 2'd0;
        player_cards <= 4'd0;
        dealer_cards <= 4'd0;
      end else begin
        if ((state == S_IDLE) && (deal_player || deal_dealer))
          tgt_player <= deal_player;
        if ((state == S_DRAW) && draw_ok)
          last_rank <= draw_rank;
        if (state == S_ADD) begin
          if (tgt_player) begin
            player_sum   <= add_sum;
            player_soft  <= soft_next;
            player_cards <= sat_cnt(player_cards);
          end else begin
            dealer_sum   <= add_sum;
            dealer_soft  <= soft_next;
            dealer_cards <= sat_cnt(dealer_cards);
          end
        end
      end
    end
  end

  // ---- status flags from registered sums ----
  assign player_bust = (player_sum > BUST6);
  assign dealer_bust = (dealer_sum > BUST6);

`ifdef HIT_SOFT17_EN
  assign dealer_auto_hit = ((dealer_sum < STAND6) && !dealer_bust) ||
                           ((dealer_sum == 6'd17) && (dealer_soft != 2'd0));
`else
  assign dealer_auto_hit = (dealer_sum < STAND6) && !dealer_bust;
`endif

endmodule

// File: tb/tb_card_dealer.sv
module tb_card_dealer;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       deal_player = 1'b0;
  logic       deal_dealer = 1'b0;
  logic       clear_sums = 1'b0;
  logic       test_en = 1'b0;
  logic [3:0] test_rank = 4'd0;
  logic       card_ready;
  logic [3:0] last_rank;
  logic [5:0] player_sum, dealer_sum;
  logic       player_bust, dealer_bust, dealer_auto_hit;
  logic [3:0] player_cards, dealer_cards;

  card_dealer dut (
    .clk(clk), .rst(rst), .deal_player(deal_player), .deal_dealer(deal_dealer),
    .clear_sums(clear_sums), .test_en(test_en), .test_rank(test_rank),
    .card_ready(card_ready), .last_rank(last_rank),
    .player_sum(player_sum), .dealer_sum(dealer_sum),
    .player_bust(player_bust), .dealer_bust(dealer_bust),
    .dealer_auto_hit(dealer_auto_hit),
    .player_cards(player_cards), .dealer_cards(dealer_cards)
  );

  always #5 clk = ~clk;

  int vecs = 0;
  int errs = 0;

  // Reference hands: index 0 = player, 1 = dealer
  int msum[2];
  int msoft[2];
  int mcnt[2];

  logic [22:0] obs;
  assign obs = {player_sum, dealer_sum, player_cards, dealer_cards,
                player_bust, dealer_bust, dealer_auto_hit};

  task automatic model_clear();
    for (int i = 0; i < 2; i++) begin
      msum[i] = 0; msoft[i] = 0; mcnt[i] = 0;
    end
  endtask

  // Blackjack hand rules in plain arithmetic
  task automatic model_add(input int who, input int rank);
    int v;
    v = (rank == 1) ? 11 : ((rank >= 10) ? 10 : rank);
    msum[who] += v;
    if (rank == 1) msoft[who]++;
    if (msum[who] > 21 && msoft[who] > 0) begin
      msum[who] -= 10;
      msoft[who]--;
    end
    if (msum[who] > 63) msum[who] = 63;
    if (mcnt[who] < 15) mcnt[who]++;
  endtask

  function automatic logic [22:0] exp_vec();
    logic ah;
    ah = (msum[1] < 17) && (msum[1] <= 21);
`ifdef HIT_SOFT17_EN
    if (msum[1] == 17 && msoft[1] > 0) ah = 1'b1;
`endif
    return {6'(msum[0]), 6'(msum[1]), 4'(mcnt[0]), 4'(mcnt[1]),
            (msum[0] > 21), (msum[1] > 21), ah};
  endfunction

  function automatic int norm(input int r);
    return (r == 0 || r > 13) ? 13 : r;
  endfunction

  // First valid rank drawn after the LFSR restarts from seed
  function automatic int first_rank(input logic [15:0] seed);
    logic [15:0] l;
    l = seed;
    for (int k = 0; k < 100; k++) begin
      l = {l[14:0], l[15] ^ l[13] ^ l[12] ^ l[10]};
      if (l[3:0] >= 4'd1 && l[3:0] <= 4'd13) return int'(l[3:0]);
    end
    return -1;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_clear();
    clear_sums = 1'b1;
    step();
    clear_sums = 1'b0;
    model_clear();
  endtask

  // Full handshake; lat = cycles from request to card_ready, 0 on timeout.
  // Returns in IDLE with requests low.
  task automatic deal(input int who, input int rank, input bit use_test, output int lat);
    test_en   = use_test;
    test_rank = 4'(rank);
    if (who == 0) deal_player = 1'b1; else deal_dealer = 1'b1;
    lat = 0;
    for (int i = 1; i <= 60; i++) begin
      step();
      if (card_ready) begin lat = i; break; end
    end
    deal_player = 1'b0;
    deal_dealer = 1'b0;
    step();
    step();
  endtask

  task automatic test_reset();
    rst = 1'b0;
    repeat (3) step();
    model_clear();
    vecs++; if (obs !== exp_vec()) begin errs++; $display("FAIL reset_status got %h want %h", obs, exp_vec()); end
    vecs++; if (card_ready !== 1'b0) begin errs++; $display("FAIL reset_ready got %b want 0", card_ready); end
    vecs++; if (last_rank !== 4'd0) begin errs++; $display("FAIL reset_rank got %0d want 0", last_rank); end
    vecs++; if (dealer_auto_hit !== 1'b1) begin errs++; $display("FAIL reset_autohit got %b want 1", dealer_auto_hit); end
    rst = 1'b1;
    step();
  endtask

  task automatic test_latency();
    test_en = 1'b1; test_rank = 4'd10; deal_player = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      step();
      vecs++; if (card_ready !== (i == 3)) begin errs++; $display("FAIL latency_c%0d got %b want %b", i, card_ready, (i == 3)); end
    end
    model_add(0, 10);
    vecs++; if (obs !== exp_vec()) begin errs++; $display("FAIL latency_status got %h want %h", obs, exp_vec()); end
    vecs++; if (player_sum !== 6'd10 || player_cards !== 4'd1) begin errs++; $display("FAIL latency_sum got %0d/%0d want 10/1", player_sum, player_cards); end
    step();
    vecs++; if (card_ready !== 1'b1) begin errs++; $display("FAIL ready_held got %b want 1", card_ready); end
    deal_player = 1'b0;
    step();
    vecs++; if (card_ready !== 1'b1) begin errs++; $display("FAIL hold_cycle got %b want 1", card_ready); end
    step();
    vecs++; if (card_ready !== 1'b0) begin errs++; $display("FAIL after_hold got %b want 0", card_ready); end
    step();
    vecs++; if (card_ready !== 1'b0) begin errs++; $display("FAIL idle_ready got %b want 0", card_ready); end
  endtask

  task automatic test_soft_ace();
    int ranks[3] = '{1, 1, 9};
    int exp_ps[3] = '{11, 12, 21};
    int lat;
    do_clear();
    for (int i = 0; i < 3; i++) begin
      deal(0, ranks[i], 1'b1, lat);
      model_add(0, ranks[i]);
      vecs++; if (lat != 3) begin errs++; $display("FAIL soft_lat%0d got %0d want 3", i, lat); end
      vecs++; if (obs !== exp_vec()) begin errs++; $display("FAIL soft_status%0d got %h want %h", i, obs, exp_vec()); end
      vecs++; if (player_sum !== 6'(exp_ps[i]) || player_bust !== 1'b0) begin errs++; $display("FAIL soft_sum%0d got %0d/%b want %0d/0", i, player_sum, player_bust, exp_ps[i]); end
    end
  endtask

  task automatic test_bust();
    int ranks[4] = '{10, 6, 13, 5};
    int exp_ps[4] = '{10, 16, 26, 31};
    int lat;
    do_clear();
    for (int i = 0; i < 4; i++) begin
      deal(0, ranks[i], 1'b1, lat);
      model_add(0, ranks[i]);
      vecs++; if (obs !== exp_vec()) begin errs++; $display("FAIL bust_status%0d got %h want %h", i, obs, exp_vec()); end
      vecs++; if (player_sum !== 6'(exp_ps[i]) || player_bust !== (i >= 2)) begin errs++; $display("FAIL bust_sum%0d got %0d/%b want %0d/%b", i, player_sum, player_bust, exp_ps[i], (i >= 2)); end
    end
    do_clear();
    vecs++; if (player_sum !== 6'd0 || player_bust !== 1'b0 || player_cards !== 4'd0) begin errs++; $display("FAIL bust_clear got %0d/%b/%0d want 0/0/0", player_sum, player_bust, player_cards); end
  endtask

  task automatic test_dealer();
    int ranks[3] = '{10, 6, 1};
    int exp_ah[3] = '{1, 1, 0};
    int lat;
    bit soft_ah;
    do_clear();
    for (int i = 0; i < 3; i++) begin
      deal(1, ranks[i], 1'b1, lat);
      model_add(1, ranks[i]);
      vecs++; if (obs !== exp_vec()) begin errs++; $display("FAIL dealer_status%0d got %h want %h", i, obs, exp_vec()); end
      vecs++; if (dealer_auto_hit !== 1'(exp_ah[i])) begin errs++; $display("FAIL dealer_ah%0d got %b want %0d", i, dealer_auto_hit, exp_ah[i]); end
    end
    vecs++; if (dealer_sum !== 6'd17) begin errs++; $display("FAIL dealer_hard17 got %0d want 17", dealer_sum); end
    do_clear();
    deal(1, 1, 1'b1, lat); model_add(1, 1);
    deal(1, 6, 1'b1, lat); model_add(1, 6);
`ifdef HIT_SOFT17_EN
    soft_ah = 1'b1;
`else
    soft_ah = 1'b0;
`endif
    vecs++; if (obs !== exp_vec()) begin errs++; $display("FAIL soft17_status got %h want %h", obs, exp_vec()); end
    vecs++; if (dealer_sum !== 6'd17 || dealer_auto_hit !== soft_ah) begin errs++; $display("FAIL soft17_ah got %0d/%b want 17/%b", dealer_sum, dealer_auto_hit, soft_ah); end
  endtask

  task automatic test_both_and_abort();
    int lat;
    do_clear();
    test_en = 1'b1; test_rank = 4'd5;
    deal_player = 1'b1; deal_dealer = 1'b1;
    lat = 0;
    for (int i = 1; i <= 10; i++) begin
      step();
      if (card_ready) begin lat = i; break; end
    end
    deal_player = 1'b0; deal_dealer = 1'b0;
    step(); step();
    model_add(0, 5);
    vecs++; if (lat != 3) begin errs++; $display("FAIL both_lat got %0d want 3", lat); end
    vecs++; if (player_sum !== 6'd5 || dealer_sum !== 6'd0) begin errs++; $display("FAIL both_sums got %0d/%0d want 5/0", player_sum, dealer_sum); end
    vecs++; if (obs !== exp_vec()) begin errs++; $display("FAIL both_status got %h want %h", obs, exp_vec()); end
    // abort: request into DRAW, then ADD, clear while in ADD
    test_rank = 4'd9;
    deal_player = 1'b1;
    step();
    step();
    clear_sums = 1'b1; deal_player = 1'b0;
    step();
    clear_sums = 1'b0;
    model_clear();
    for (int i = 0; i < 4; i++) begin
      vecs++; if (card_ready !== 1'b0) begin errs++; $display("FAIL abort_ready%0d got %b want 0", i, card_ready); end
      step();
    end
    vecs++; if (obs !== exp_vec()) begin errs++; $display("FAIL abort_status got %h want %h", obs, exp_vec()); end
    deal(0, 7, 1'b1, lat);
    model_add(0, 7);
    vecs++; if (lat != 3) begin errs++; $display("FAIL abort_idle_lat got %0d want 3", lat); end
    vecs++; if (obs !== exp_vec()) begin errs++; $display("FAIL abort_next got %h want %h", obs, exp_vec()); end
  endtask

  task automatic test_reset_mid_ready();
    int lat;
    int want;
    do_clear();
    test_en = 1'b1; test_rank = 4'd9; deal_player = 1'b1;
    lat = 0;
    for (int i = 1; i <= 10; i++) begin
      step();
      if (card_ready) begin lat = i; break; end
    end
    vecs++; if (lat == 0) begin errs++; $display("FAIL rstmid_reach got timeout want ready"); end
    step();
    #2 rst = 1'b0;
    #1;
    deal_player = 1'b0;
    model_clear();
    vecs++; if (card_ready !== 1'b0) begin errs++; $display("FAIL rstmid_ready got %b want 0", card_ready); end
    vecs++; if (obs !== exp_vec() || last_rank !== 4'd0) begin errs++; $display("FAIL rstmid_status got %h/%0d want %h/0", obs, last_rank, exp_vec()); end
    step();
    rst = 1'b1; test_en = 1'b0; deal_player = 1'b1;
    want = first_rank(16'hACE1);
    lat = 0;
    for (int i = 1; i <= 40; i++) begin
      step();
      if (card_ready) begin lat = i; break; end
    end
    deal_player = 1'b0;
    step(); step();
    model_add(0, want);
    vecs++; if (lat == 0 || int'(last_rank) != want) begin errs++; $display("FAIL seed_rank got %0d (lat %0d) want %0d", last_rank, lat, want); end
    vecs++; if (obs !== exp_vec()) begin errs++; $display("FAIL seed_status got %h want %h", obs, exp_vec()); end
  endtask

  task automatic test_lfsr_random();
    int lat, who;
    do_clear();
    for (int n = 0; n < 20; n++) begin
      who = int'($urandom_range(0, 1));
      deal(who, 0, 1'b0, lat);
      vecs++; if (lat == 0 || last_rank < 4'd1 || last_rank > 4'd13) begin errs++; $display("FAIL lfsr_rank%0d got %0d (lat %0d) want 1..13", n, last_rank, lat); end
      model_add(who, int'(last_rank));
      vecs++; if (obs !== exp_vec()) begin errs++; $display("FAIL lfsr_status%0d got %h want %h", n, obs, exp_vec()); end
      if (n == 9) do_clear();
    end
  endtask

  task automatic test_forced_random();
    int lat, who, r;
    do_clear();
    for (int n = 0; n < 24; n++) begin
      who = int'($urandom_range(0, 1));
      r = int'($urandom_range(0, 15));
      deal(who, r, 1'b1, lat);
      model_add(who, norm(r));
      vecs++; if (lat != 3 || int'(last_rank) != norm(r)) begin errs++; $display("FAIL forced_rank%0d got %0d (lat %0d) want %0d", n, last_rank, lat, norm(r)); end
      vecs++; if (obs !== exp_vec()) begin errs++; $display("FAIL forced_status%0d got %h want %h", n, obs, exp_vec()); end
      if (n % 8 == 7) do_clear();
    end
  endtask

  task automatic test_saturation();
    int lat;
    do_clear();
    for (int n = 0; n < 17; n++) begin
      deal(0, 10, 1'b1, lat);
      model_add(0, 10);
    end
    vecs++; if (player_sum !== 6'd63 || player_cards !== 4'd15 || player_bust !== 1'b1) begin errs++; $display("FAIL sat_limits got %0d/%0d/%b want 63/15/1", player_sum, player_cards, player_bust); end
    vecs++; if (obs !== exp_vec()) begin errs++; $display("FAIL sat_status got %h want %h", obs, exp_vec()); end
  endtask

  initial begin
    model_clear();
    test_reset();
    test_latency();
    test_soft_ace();
    test_bust();
    test_dealer();
    test_both_and_abort();
    test_reset_mid_ready();
    test_lfsr_random();
    test_forced_random();
    test_saturation();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule

// File: doc/card_dealer.md
Name: card_dealer

Overview:
- Card source and hand accumulator directly upstream of the blackjack game FSM.
- Consumes the FSM's deal_player / deal_dealer / clear_sums requests, draws a card, and updates the correct hand total with soft-ace handling.
- Returns the card_ready handshake plus player_sum, dealer_sum, dealer_bust and dealer_auto_hit to the FSM.
- A free-running LFSR supplies ranks; a switch-driven test override gives deterministic cards.

Parameters:
- LFSR_SEED, 16'hACE1, non-zero reset value of the 16-bit Fibonacci LFSR (taps 16,14,13,11).
- DEALER_STAND, 17, dealer_auto_hit deasserts once dealer_sum >= this value.
- BUST_LIMIT, 21, a sum above this value is bust.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous active-low reset
- deal_player  in  1  request one card for the player; level, held until card_ready
- deal_dealer  in  1  request one card for the dealer; level, held until card_ready
- clear_sums  in  1  clear both hands; level
- test_en  in  1  1 = use test_rank instead of the LFSR
- test_rank  in  4  forced rank 1..13
- card_ready  out  1  card committed to a hand
- last_rank  out  4  rank of the most recently committed card
- player_sum  out  6  player hand total
- dealer_sum  out  6  dealer hand total
- player_bust  out  1  player_sum > BUST_LIMIT
- dealer_bust  out  1  dealer_sum > BUST_LIMIT
- dealer_auto_hit  out  1  dealer_sum < DEALER_STAND and dealer not bust
- player_cards  out  4  cards in player hand, saturating at 15
- dealer_cards  out  4  cards in dealer hand, saturating at 15

Behaviour:
- Reset (rst=0, async): FSM=IDLE; LFSR=LFSR_SEED; all sums, counts, soft-ace counters and last_rank = 0; card_ready=0.
- Consequence of reset: dealer_auto_hit=1, both bust flags = 0.
- The LFSR advances every cycle whenever rst=1.
- Rank source: LFSR[3:0] when test_en=0; otherwise test_rank. A test_rank of 0 or >13 is treated as 13.
- Card value: rank 1 = 11 (soft ace); ranks 2..10 = face value; ranks 11..13 = 10.
- FSM states: IDLE, DRAW, ADD, READY, HOLD.
  - IDLE: if deal_player or deal_dealer, latch the target (player wins if both are high) and go to DRAW.
  - DRAW: sample the rank.
    - If test_en=0 and LFSR[3:0] is 0, 14 or 15: stay in DRAW, retry next cycle.
    - Otherwise latch rank into last_rank and go to ADD.
  - ADD: sum_next = sum + value (computed in 7 bits).
    - If the card was an ace, increment the soft-ace count.
    - If sum_next > BUST_LIMIT and soft count > 0: subtract 10 and decrement soft count (at most once per card).
    - Result saturates at 63. Card count +1, saturating at 15. Go to READY.
  - READY: card_ready=1. When the latched request input drops, go to HOLD.
  - HOLD: card_ready=1 for exactly one cycle, then IDLE. This lets the consumer's post-deal wait state still observe card_ready.
- Latency: request sampled in IDLE at cycle N gives card_ready=1 at N+3 when no LFSR retries occur.
- card_ready is registered and high only in READY/HOLD.
- Requests arriving outside IDLE are ignored until IDLE returns. A request still high on return to IDLE starts a new card.
- clear_sums=1: synchronously zero sums, counts and soft counters; FSM forced to IDLE; card_ready=0.
  - This aborts any in-flight card, which is not committed.
  - clear_sums has priority over any request in the same cycle.
- Flags are combinational from the registered sums; they update the cycle after ADD.
- Sums keep accumulating after bust (saturating at 63); bust flags stay set until clear_sums.

Optional Feature:
- Macro HIT_SOFT17_EN.
- Defined: dealer_auto_hit is also 1 when dealer_sum == 17 and the dealer soft-ace count > 0 (dealer hits soft 17).
- Undefined: dealer_auto_hit = (dealer_sum < DEALER_STAND) && !dealer_bust, with no soft check.

Test Plan:
- test_en=1, test_rank=10, deal_player held from cycle 0 → card_ready=1 at cycle 3, player_sum=10, player_cards=1. After deal_player drops, card_ready stays high exactly 1 more cycle, then 0.
- Player cards 1 then 1 (test_rank=1) → sums 11, then 12 (second ace demoted); third card 9 → 21, player_bust=0.
- Player cards 10, 6, 13 → player_sum=26, player_bust=1; a further card 5 → 31; clear_sums → 0, player_bust=0.
- Dealer cards 10, 6 → dealer_auto_hit=1; card 1 → dealer_sum=17, dealer_auto_hit=0 (macro undefined). With HIT_SOFT17_EN and dealer cards 1, 6 → sum 17, dealer_auto_hit=1.
- deal_player and deal_dealer high together with test_rank=5 → player_sum=5, dealer_sum=0. Then assert clear_sums in ADD → sums 0, card_ready never asserts, FSM returns to IDLE.
- rst pulsed low mid-READY → card_ready=0 immediately; sums 0; LFSR back to LFSR_SEED. test_en=0 draws: last_rank always within 1..13.
